// File: rtl/sseg_scan_capture.sv
// sseg_scan_capture: recovers per-digit hex/dp/blank/valid from a multiplexed
// active-low seven-segment bus (an, sseg), with frame, error and staleness status.
// Ports: clk, reset (sync, active-high), an[3:0], sseg[7:0] in;
//        hex0..hex3[3:0], dp[3:0], digit_valid[3:0], blank[3:0],
//        frame_done, scan_err, stale out.
// Optional: define SSEG_CAP_FRAME_CNT_EN to add frame_cnt[15:0] (frames seen).
module sseg_scan_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 2**20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [7:0]  sseg,
    output logic [3:0]  hex0,
    output logic [3:0]  hex1,
    output logic [3:0]  hex2,
    output logic [3:0]  hex3,
    output logic [3:0]  dp,
    output logic [3:0]  digit_valid,
    output logic [3:0]  blank,
    output logic        frame_done,
    output logic        scan_err,
    output logic        stale
`ifdef SSEG_CAP_FRAME_CNT_EN
    ,
    output logic [15:0] frame_cnt
`endif
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = $clog2(TIMEOUT_CYCLES + 1);

    logic [11:0]   in_q, in_d;
    logic [11:0]   prev_q, prev_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [3:0]    hex_q [4];
    logic [3:0]    hex_d [4];
    logic [3:0]    dp_q, dp_d;
    logic [3:0]    valid_q, valid_d;
    logic [3:0]    blank_q, blank_d;
    logic [3:0]    seen_q, seen_d;
    logic          fd_q, fd_d;
    logic          err_q, err_d;
    logic          stale_q, stale_d;
`ifdef SSEG_CAP_FRAME_CNT_EN
    logic [15:0]   fcnt_q, fcnt_d;
`endif

    logic          changed;
    logic          accept;
    logic [3:0]    sel;
    logic [1:0]    idx;
    logic [3:0]    gval;
    logic          gmatch;
    logic [3:0]    seen_nx;

    // Anode and glyph decode of the registered bus.
    always_comb begin
        sel = 4'b0000;
        idx = 2'd0;
        case (in_q[11:8])
            4'b1110: begin sel = 4'b0001; idx = 2'd0; end
            4'b1101: begin sel = 4'b0010; idx = 2'd1; end
            4'b1011: begin sel = 4'b0100; idx = 2'd2; end
            4'b0111: begin sel = 4'b1000; idx = 2'd3; end
            default: begin sel = 4'b0000; idx = 2'd0; end
        endcase

        gmatch = 1'b1;
        gval   = 4'h0;
        case (in_q[6:0])
            7'h01: gval = 4'h0;
            7'h4F: gval = 4'h1;
            7'h12: gval = 4'h2;
            7'h06: gval = 4'h3;
            7'h4C: gval = 4'h4;
            7'h24: gval = 4'h5;
            7'h20: gval = 4'h6;
            7'h0F: gval = 4'h7;
            7'h00: gval = 4'h8;
            7'h04: gval = 4'h9;
            7'h08: gval = 4'hA;
            7'h60: gval = 4'hB;
            7'h31: gval = 4'hC;
            7'h42: gval = 4'hD;
            7'h30: gval = 4'hE;
            7'h38: gval = 4'hF;
            default: begin gmatch = 1'b0; gval = 4'h0; end
        endcase
    end

    always_comb begin
        in_d    = {an, sseg};
        prev_d  = in_q;
        changed = (in_q != prev_q);
        // Accept fires once: cnt passes STABLE_CYCLES-1 only once per stable run.
        accept  = !changed && (cnt_q == CW'(STABLE_CYCLES - 1));

        if (changed)
            cnt_d = '0;
        else if (cnt_q == CW'(STABLE_CYCLES))
            cnt_d = cnt_q;
        else
            cnt_d = cnt_q + CW'(1);

        hex_d   = hex_q;
        dp_d    = dp_q;
        valid_d = valid_q;
        blank_d = blank_q;
        seen_d  = seen_q;
        fd_d    = 1'b0;
        err_d   = err_q;
        stale_d = stale_q;
        seen_nx = seen_q | sel;
`ifdef SSEG_CAP_FRAME_CNT_EN
        fcnt_d  = fcnt_q;
`endif

        if (accept) begin
            idle_d = '0;
            if (sel != 4'b0000) begin
                hex_d[idx]   = gval;
                valid_d[idx] = gmatch;
                blank_d[idx] = (in_q[6:0] == 7'h7F);
                dp_d[idx]    = ~in_q[7];
                stale_d      = 1'b0;
                if (seen_nx == 4'b1111) begin
                    fd_d   = 1'b1;
                    seen_d = 4'b0000;
`ifdef SSEG_CAP_FRAME_CNT_EN
                    fcnt_d = fcnt_q + 16'd1;
`endif
                end else begin
                    seen_d = seen_nx;
                end
            end else if (in_q[11:8] != 4'b1111) begin
                err_d = 1'b1;
            end
        end else begin
            if (idle_q == IW'(TIMEOUT_CYCLES))
                idle_d = idle_q;
            else
                idle_d = idle_q + IW'(1);
            // Fires on the single edge idle saturates; hex/dp keep last value.
            if (idle_q == IW'(TIMEOUT_CYCLES - 1)) begin
                stale_d = 1'b1;
                valid_d = 4'b0000;
                blank_d = 4'b0000;
                seen_d  = 4'b0000;
`ifdef SSEG_CAP_FRAME_CNT_EN
                fcnt_d  = 16'd0;
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_q    <= 12'hFFF;
            prev_q  <= 12'hFFF;
            cnt_q   <= '0;
            idle_q  <= '0;
            for (int i = 0; i < 4; i++) hex_q[i] <= 4'h0;
            dp_q    <= 4'b0000;
            valid_q <= 4'b0000;
            blank_q <= 4'b0000;
            seen_q  <= 4'b0000;
            fd_q    <= 1'b0;
            err_q   <= 1'b0;
            stale_q <= 1'b0;
`ifdef SSEG_CAP_FRAME_CNT_EN
            fcnt_q  <= 16'd0;
`endif
        end else begin
            in_q    <= in_d;
            prev_q  <= prev_d;
            cnt_q   <= cnt_d;
            idle_q  <= idle_d;
            hex_q   <= hex_d;
            dp_q    <= dp_d;
            valid_q <= valid_d;
            blank_q <= blank_d;
            seen_q  <= seen_d;
            fd_q    <= fd_d;
            err_q   <= err_d;
            stale_q <= stale_d;
`ifdef SSEG_CAP_FRAME_CNT_EN
            fcnt_q  <= fcnt_d;
`endif
        end
    end

    assign hex0        = hex_q[0];
    assign hex1        = hex_q[1];
    assign hex2        = hex_q[2];
    assign hex3        = hex_q[3];
    assign dp          = dp_q;
    assign digit_valid = valid_q;
    assign blank       = blank_q;
    assign frame_done  = fd_q;
    assign scan_err    = err_q;
    assign stale       = stale_q;
`ifdef SSEG_CAP_FRAME_CNT_EN
    assign frame_cnt   = fcnt_q;
`endif

endmodule

// File: tb/tb_sseg_scan_capture.sv
// Directed bench for sseg_scan_capture (STABLE_CYCLES=4, TIMEOUT_CYCLES=32).
// Expected values are hand-computed from the glyph table and timing rules.
module tb_sseg_scan_capture;

    logic        clk;
    logic        reset;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic [3:0]  hex0, hex1, hex2, hex3;
    logic [3:0]  dp, digit_valid, blank;
    logic        frame_done, scan_err, stale;
`ifdef SSEG_CAP_FRAME_CNT_EN
    logic [15:0] frame_cnt;
`endif

    int total;
    int bad;
    int fd_cnt;
    int fd_ref;

    sseg_scan_capture #(
        .STABLE_CYCLES  (4),
        .TIMEOUT_CYCLES (32)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .an          (an),
        .sseg        (sseg),
        .hex0        (hex0),
        .hex1        (hex1),
        .hex2        (hex2),
        .hex3        (hex3),
        .dp          (dp),
        .digit_valid (digit_valid),
        .blank       (blank),
        .frame_done  (frame_done),
        .scan_err    (scan_err),
        .stale       (stale)
`ifdef SSEG_CAP_FRAME_CNT_EN
        ,
        .frame_cnt   (frame_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            if (frame_done === 1'b1) fd_cnt++;
        end
    endtask

    task automatic put(input logic [3:0] a, input logic [7:0] s);
        an   = a;
        sseg = s;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] hexes();
        return {hex3, hex2, hex1, hex0};
    endfunction

    initial begin
        total  = 0;
        bad    = 0;
        fd_cnt = 0;
        reset  = 1'b1;
        put(4'hF, 8'hFF);
        step(3);
        reset = 1'b0;

        chk("rst_hex", 32'(hexes()), 32'h0000);
        chk("rst_dp", 32'(dp), 32'h0);
        chk("rst_valid", 32'(digit_valid), 32'h0);
        chk("rst_blank", 32'(blank), 32'h0);
        chk("rst_fd", 32'(frame_done), 32'h0);
        chk("rst_err", 32'(scan_err), 32'h0);
        chk("rst_stale", 32'(stale), 32'h0);

        // Single digit, latency exactly 6 edges
        put(4'hE, 8'h81);
        step(5);
        chk("t1_edge5_valid", 32'(digit_valid), 32'h0);
        step(1);
        chk("t1_edge6_valid", 32'(digit_valid), 32'h1);
        chk("t1_hex", 32'(hexes()), 32'h0000);
        chk("t1_dp", 32'(dp), 32'h0);
        chk("t1_fd", 32'(frame_done), 32'h0);
        step(4);

        // Full frame with blank digit and lit dp on digit 3
        put(4'hE, 8'hCF); step(8);
        put(4'hD, 8'h92); step(8);
        put(4'hB, 8'hFF); step(8);
        put(4'h7, 8'h38);
        fd_ref = fd_cnt;
        step(5);
        chk("t2_fd_early", 32'(frame_done), 32'h0);
        step(1);
        chk("t2_fd_pulse", 32'(frame_done), 32'h1);
        chk("t2_hex", 32'(hexes()), 32'hF021);
        chk("t2_blank", 32'(blank), 32'h4);
        chk("t2_valid", 32'(digit_valid), 32'hB);
        chk("t2_dp", 32'(dp), 32'h8);
        step(1);
        chk("t2_fd_drop", 32'(frame_done), 32'h0);
        step(1);
        chk("t2_fd_count", 32'(fd_cnt - fd_ref), 32'd1);
`ifdef SSEG_CAP_FRAME_CNT_EN
        chk("t2_fcnt", 32'(frame_cnt), 32'd1);
`endif

        // All-off anode never errors; non-one-hot does, stickily
        put(4'hF, 8'hFF); step(8);
        chk("t3_off_err", 32'(scan_err), 32'h0);
        put(4'h9, 8'h00); step(8);
        chk("t3_err", 32'(scan_err), 32'h1);
        chk("t3_hex", 32'(hexes()), 32'hF021);
        chk("t3_valid", 32'(digit_valid), 32'hB);
        put(4'hF, 8'hFF); step(8);
        chk("t3_sticky", 32'(scan_err), 32'h1);

        // Glitching bus never stabilises long enough
        for (int i = 0; i < 6; i++) begin
            if (i % 2 == 0) put(4'hE, 8'hA4);
            else            put(4'hE, 8'hA0);
            step(2);
        end
        chk("t4_glitch_hex", 32'(hexes()), 32'hF021);
        chk("t4_glitch_valid", 32'(digit_valid), 32'hB);
        put(4'hE, 8'h92);
        step(5);
        chk("t4_edge5_hex", 32'(hexes()), 32'hF021);
        step(1);
        chk("t4_edge6_hex", 32'(hexes()), 32'hF022);
        step(2);

        // Full frame incl. unrecognised glyph, then timeout
        fd_ref = fd_cnt;
        put(4'hE, 8'hC0); step(8);
        put(4'hD, 8'h88); step(8);
        put(4'hB, 8'hE0); step(8);
        put(4'h7, 8'hC2); step(8);
        chk("t5_fd_count", 32'(fd_cnt - fd_ref), 32'd1);
        chk("t5_hex", 32'(hexes()), 32'hDBA0);
        chk("t5_valid", 32'(digit_valid), 32'hE);
        chk("t5_blank", 32'(blank), 32'h0);
        chk("t5_dp", 32'(dp), 32'h0);
`ifdef SSEG_CAP_FRAME_CNT_EN
        chk("t5_fcnt", 32'(frame_cnt), 32'd2);
`endif
        put(4'hF, 8'hFF);
        step(37);
        chk("t5_stale_early", 32'(stale), 32'h0);
        step(1);
        chk("t5_stale", 32'(stale), 32'h1);
        chk("t5_stale_valid", 32'(digit_valid), 32'h0);
        chk("t5_stale_hex", 32'(hexes()), 32'hDBA0);
`ifdef SSEG_CAP_FRAME_CNT_EN
        chk("t5_stale_fcnt", 32'(frame_cnt), 32'd0);
`endif
        put(4'hD, 8'hA4);
        step(5);
        chk("t5_still_stale", 32'(stale), 32'h1);
        step(1);
        chk("t5_unstale", 32'(stale), 32'h0);
        chk("t5_new_hex", 32'(hexes()), 32'hDB50);
        chk("t5_new_valid", 32'(digit_valid), 32'h2);
        step(2);

        // Reset mid-frame, then one clean scan
        put(4'hE, 8'h81); step(8);
        chk("t6_pre_valid", 32'(digit_valid), 32'h3);
        put(4'hB, 8'h92); step(3);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("t6_rst_hex", 32'(hexes()), 32'h0000);
        chk("t6_rst_valid", 32'(digit_valid), 32'h0);
        chk("t6_rst_dp", 32'(dp), 32'h0);
        chk("t6_rst_err", 32'(scan_err), 32'h0);
        fd_ref = fd_cnt;
        step(5);
        chk("t6_edge5_valid", 32'(digit_valid), 32'h0);
        step(1);
        chk("t6_edge6_valid", 32'(digit_valid), 32'h4);
        chk("t6_edge6_hex", 32'(hexes()), 32'h0200);
        step(2);
        put(4'hE, 8'h81); step(8);
        put(4'hD, 8'hCF); step(8);
        put(4'h7, 8'h86); step(8);
        put(4'hF, 8'hFF); step(8);
        chk("t6_fd_count", 32'(fd_cnt - fd_ref), 32'd1);
        chk("t6_hex", 32'(hexes()), 32'h3210);
        chk("t6_valid", 32'(digit_valid), 32'hF);
`ifdef SSEG_CAP_FRAME_CNT_EN
        chk("t6_fcnt", 32'(frame_cnt), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
